// File: rtl/program_sequencer_if.sv
// Harness <-> run-controller bundle for program_sequencer.
// Ports: start/prog_sel/inst/stall_req come from the harness and fetch_unit;
//        fetch_init/fetch_en/start_address/busy/done/timeout/cycle_count go back.
interface program_sequencer_if #(
   parameter int ADDR_W = 9,
   parameter int INST_W = 9,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [1:0]        prog_sel;
   logic [INST_W-1:0] inst;
   logic              stall_req;
   logic              fetch_init;
   logic              fetch_en;
   logic [ADDR_W-1:0] start_address;
   logic              busy;
   logic              done;
   logic              timeout;
   logic [CNT_W-1:0]  cycle_count;

   // master: harness / fetch side that drives requests and instructions
   modport master (
      output start, prog_sel, inst, stall_req,
      input  fetch_init, fetch_en, start_address, busy, done, timeout, cycle_count
   );

   // slave: the sequencer itself
   modport slave (
      input  start, prog_sel, inst, stall_req,
      output fetch_init, fetch_en, start_address, busy, done, timeout, cycle_count
   );
endinterface

// File: rtl/program_sequencer.sv
// Run controller for fetch_unit: looks up a program start address, pulses
// fetch init for one cycle, then enables fetch until HALT or watchdog expiry.
// Ports: clk, reset (sync, active-high), bus (program_sequencer_if.slave).
module program_sequencer #(
   parameter int                ADDR_W      = 9,
   parameter int                INST_W      = 9,
   parameter int                CNT_W       = 16,
   parameter logic [INST_W-1:0] HALT_OPCODE = 9'b000000001,
   parameter logic [ADDR_W-1:0] PROG0_ADDR  = 9'd0,
   parameter logic [ADDR_W-1:0] PROG1_ADDR  = 9'd64,
   parameter logic [ADDR_W-1:0] PROG2_ADDR  = 9'd128,
   parameter logic [ADDR_W-1:0] PROG3_ADDR  = 9'd256,
   parameter logic [CNT_W-1:0]  MAX_CYCLES  = 16'hFFFF
) (
   input  logic                clk,
   input  logic                reset,
   program_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] WD_LAST = MAX_CYCLES - CNT_ONE;

   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] start_address_q;
   logic [CNT_W-1:0]  cycle_count_q;
   logic              timeout_q;
   logic [ADDR_W-1:0] prog_addr;
   logic              fetch_init, fetch_en, busy, done, wd_hit;

   always_comb begin
      prog_addr = PROG0_ADDR;
      case (bus.prog_sel)
         2'd0:    prog_addr = PROG0_ADDR;
         2'd1:    prog_addr = PROG1_ADDR;
         2'd2:    prog_addr = PROG2_ADDR;
         default: prog_addr = PROG3_ADDR;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      fetch_init = 1'b0;
      fetch_en   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      wd_hit     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = INIT;
         end
         INIT: begin
            fetch_init = 1'b1;
            fetch_en   = 1'b1;
            busy       = 1'b1;
            state_d    = RUN;
         end
         RUN: begin
            busy     = 1'b1;
            fetch_en = ~bus.stall_req;
            // A stalled cycle carries a stale inst, so neither HALT nor the
            // watchdog is evaluated until the datapath frees up.
            if (!bus.stall_req) begin
               if (bus.inst == HALT_OPCODE) begin
                  fetch_en = 1'b0;   // leave pc parked on the HALT word
                  state_d  = DONE;
               end else if (cycle_count_q >= WD_LAST) begin
                  // >= rather than == so a stall landing on the limit cycle
                  // cannot let the run slip past the watchdog.
                  wd_hit  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         start_address_q <= '0;
         cycle_count_q   <= '0;
         timeout_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.start) begin
            start_address_q <= prog_addr;
            cycle_count_q   <= '0;
            timeout_q       <= 1'b0;
         end
         if (state_q == RUN) begin
            if (cycle_count_q != '1) cycle_count_q <= cycle_count_q + CNT_ONE;
            if (wd_hit) timeout_q <= 1'b1;
         end
      end
   end

   assign bus.fetch_init    = fetch_init;
   assign bus.fetch_en      = fetch_en;
   assign bus.busy          = busy;
   assign bus.done          = done;
   assign bus.start_address = start_address_q;
   assign bus.cycle_count   = cycle_count_q;
   assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a small fetch_unit model and ROM.
// Watchdog limit is set to 16 RUN cycles so the timeout path is reachable.
// Ports: none (top-level bench).
module tb_program_sequencer;

   localparam logic [8:0] NOP  = 9'h010;
   localparam logic [8:0] HALT = 9'h001;

   logic       clk;
   logic       reset;
   logic [8:0] pc;
   logic [8:0] rom [0:511];
   int         checks;
   int         errors;
   int         run_cyc;
   int         inits;

   program_sequencer_if #(.ADDR_W(9), .INST_W(9), .CNT_W(16)) bus ();

   program_sequencer #(.MAX_CYCLES(16'd16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fetch_unit model: init loads the start address, enable advances pc
   always_ff @(posedge clk) begin
      if (bus.fetch_init)    pc <= bus.start_address;
      else if (bus.fetch_en) pc <= pc + 9'd1;
   end

   always_comb bus.inst = rom[pc];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fetch_init"}, bus.fetch_init, 0);
      check({tag, "_fetch_en"}, bus.fetch_en, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_timeout"}, bus.timeout, 0);
      check({tag, "_start_address"}, bus.start_address, 0);
      check({tag, "_cycle_count"}, bus.cycle_count, 0);
   endtask

   // Called on the INIT cycle; returns on the DONE cycle (bounded).
   task automatic wait_done(input string tag, output int rc, output int ni);
      int n;
      rc = 0;
      ni = 0;
      n  = 0;
      while (bus.done !== 1'b1 && n < 200) begin
         if (bus.fetch_init === 1'b1) ni++;
         else if (bus.busy === 1'b1) rc++;
         tick();
         n++;
      end
      check({tag, "_done_seen"}, bus.done, 1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      pc     = 9'd0;
      for (int i = 0; i < 512; i++) rom[i] = NOP;
      rom[2]   = HALT;                  // prog 0: NOP, NOP, HALT
      rom[128] = 9'h0AA;                // prog 2: 0AA, HALT
      rom[129] = HALT;
      rom[256] = 9'h055;                // prog 3: 055, 066, HALT
      rom[257] = 9'h066;
      rom[258] = HALT;                  // prog 1 (64..) has no HALT
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.prog_sel  = 2'd0;
      bus.stall_req = 1'b0;

      // reset state
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;

      // 1: program 0, plain run
      bus.start = 1'b1; bus.prog_sel = 2'd0;
      tick();
      bus.start = 1'b0;
      check("t1_init_fetch_init", bus.fetch_init, 1);
      check("t1_init_fetch_en", bus.fetch_en, 1);
      check("t1_init_busy", bus.busy, 1);
      check("t1_start_address", bus.start_address, 0);
      tick();
      check("t1_run1_fetch_init", bus.fetch_init, 0);
      check("t1_run1_inst", bus.inst, NOP);
      tick();
      tick();
      check("t1_run3_inst", bus.inst, HALT);
      check("t1_halt_fetch_en", bus.fetch_en, 0);
      check("t1_halt_done", bus.done, 0);
      tick();
      check("t1_done", bus.done, 1);
      check("t1_done_busy", bus.busy, 0);
      check("t1_cycle_count", bus.cycle_count, 3);
      check("t1_timeout", bus.timeout, 0);
      check("t1_pc_on_halt", pc, 2);
      tick();
      check("t1_idle_done", bus.done, 0);

      // 2: program 0, stall for 2 cycles while HALT is on inst
      bus.start = 1'b1; bus.prog_sel = 2'd0;
      tick();
      bus.start = 1'b0;
      check("t2_cycle_count_clr", bus.cycle_count, 0);
      tick();
      tick();
      tick();                           // RUN3: HALT on inst
      bus.stall_req = 1'b1;
      check("t2_stall_fetch_en", bus.fetch_en, 0);
      tick();                           // RUN4: still stalled
      check("t2_stall_pc", pc, 2);
      check("t2_stall_busy", bus.busy, 1);
      check("t2_stall_no_done", bus.done, 0);
      tick();                           // RUN5
      bus.stall_req = 1'b0;
      check("t2_after_stall_pc", pc, 2);
      check("t2_halt_fetch_en", bus.fetch_en, 0);
      tick();
      check("t2_done", bus.done, 1);
      check("t2_cycle_count", bus.cycle_count, 5);
      tick();

      // 3: program 1 has no HALT -> watchdog
      bus.start = 1'b1; bus.prog_sel = 2'd1;
      tick();
      bus.start = 1'b0;
      check("t3_start_address", bus.start_address, 64);
      wait_done("t3", run_cyc, inits);
      check("t3_run_cycles", run_cyc, 16);
      check("t3_timeout", bus.timeout, 1);
      check("t3_cycle_count", bus.cycle_count, 16);
      tick();
      check("t3_timeout_sticky", bus.timeout, 1);
      check("t3_count_hold", bus.cycle_count, 16);

      // 4: program 2 start address and first instruction
      bus.start = 1'b1; bus.prog_sel = 2'd2;
      tick();
      bus.start = 1'b0;
      check("t4_start_address", bus.start_address, 128);
      check("t4_timeout_clr", bus.timeout, 0);
      tick();
      check("t4_first_inst", bus.inst, 9'h0AA);
      wait_done("t4", run_cyc, inits);
      check("t4_cycle_count", bus.cycle_count, 2);
      tick();

      // 5: start held high through a whole run
      bus.start = 1'b1; bus.prog_sel = 2'd3;
      tick();
      wait_done("t5", run_cyc, inits);
      check("t5_single_init", inits, 1);
      check("t5_cycle_count", bus.cycle_count, 3);
      tick();
      check("t5_idle_busy", bus.busy, 0);
      check("t5_idle_fetch_init", bus.fetch_init, 0);
      tick();
      check("t5_rerun_fetch_init", bus.fetch_init, 1);
      check("t5_rerun_address", bus.start_address, 256);
      bus.start = 1'b0;
      wait_done("t5b", run_cyc, inits);
      tick();

      // 6: reset during RUN
      bus.start = 1'b1; bus.prog_sel = 2'd1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      check("t6_running", bus.busy, 1);
      reset = 1'b1;
      tick();
      check_all_zero("t6_reset");
      reset = 1'b0;
      bus.start = 1'b1; bus.prog_sel = 2'd0;
      tick();
      bus.start = 1'b0;
      check("t6_restart_fetch_init", bus.fetch_init, 1);
      wait_done("t6", run_cyc, inits);
      check("t6_cycle_count", bus.cycle_count, 3);
      check("t6_timeout", bus.timeout, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
